// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//   Multi-digit seven-segment display controller. Accepts a packed value over a
//   valid/ready handshake and displays it either as hex nibbles or as decimal
//   (double-dabble conversion, one shift per clock). Provides leading-zero
//   blanking, per-digit blink and an overflow indication for decimal values
//   that do not fit in NUM_DIGITS digits.
//
//   Ports:
//     clk       system clock, all state on rising edge
//     reset     synchronous, active-high
//     in_valid  producer has a value
//     in_ready  controller idle and able to accept
//     in_value  hex: nibble k -> digit k; decimal: unsigned binary
//     in_dec    1 = decimal mode, sampled at accept only
//     blank_lz  1 = blank leading zeros (live)
//     blink_en  bit k = digit k blinks (live)
//     overflow  last decimal value did not fit
//     HEX       active-low segments {g..a}, HEX[7k+6:7k] = digit k
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic                    in_dec,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int BCD_W = 4 * (NUM_DIGITS + 2);
    localparam int CNT_W = $clog2(W + 1);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t                  state;
    logic [W-1:0]            digit_store;
    logic [NUM_DIGITS-1:0]   dash_store;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcd_adj;
    logic [W-1:0]            shift_reg;
    logic [CNT_W-1:0]        count;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    phase;
    logic [NUM_DIGITS-1:0]   lz_blank;

    assign in_ready = (state == IDLE);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < NUM_DIGITS + 2; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            digit_store <= '0;
            dash_store  <= '0;
            bcd         <= '0;
            shift_reg   <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_dec) begin
                            shift_reg <= in_value;
                            bcd       <= '0;
                            count     <= '0;
                            state     <= CONV;
                        end else begin
                            digit_store <= in_value;
                            dash_store  <= '0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    // Adjust-then-shift in one edge; the binary MSB enters the BCD LSB.
                    bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[W-1]};
                    shift_reg <= {shift_reg[W-2:0], 1'b0};
                    count     <= count + CNT_W'(1);
                    if (count == CNT_W'(W - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    if (bcd[BCD_W-1 -: 8] != 8'd0) begin
                        overflow    <= 1'b1;
                        dash_store  <= '1;
                        digit_store <= '0;
                    end else begin
                        overflow    <= 1'b0;
                        dash_store  <= '0;
                        digit_store <= bcd[W-1:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running blink timebase, independent of loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero
    // and not dashes; digit 0 is always shown.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
            all_zero        = all_zero & (digit_store[4*(i-1) +: 4] == 4'd0)
                                       & ~dash_store[i-1];
            lz_blank[i-1]   = all_zero;
        end
        lz_blank[0] = 1'b0;
    end

    always_comb begin
        HEX = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (phase && blink_en[i])
                HEX[7*i +: 7] = SEG_BLANK;
            else if (blank_lz && lz_blank[i])
                HEX[7*i +: 7] = SEG_BLANK;
            else if (dash_store[i])
                HEX[7*i +: 7] = SEG_DASH;
            else
                HEX[7*i +: 7] = glyph(digit_store[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_value;
    logic        in_dec;
    logic        blank_lz;
    logic [5:0]  blink_en;
    logic        overflow;
    logic [41:0] HEX;

    hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_dec(in_dec), .blank_lz(blank_lz),
        .blink_en(blink_en), .overflow(overflow), .HEX(HEX)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; blink phase = (edges/4) % 2.
    int unsigned n_edges = 0;
    always @(posedge clk) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Digit codes: 8'h00..8'h0F glyph, 8'h10 DASH, 8'h11 BLANK; packed {d5..d0}.
    typedef struct {
        logic [23:0] value;
        logic        dec;
        logic        lz;
        logic [47:0] codes;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    localparam logic [47:0] C_123456 = 48'h01_02_03_04_05_06;
    localparam logic [47:0] C_ZERO   = 48'h00_00_00_00_00_00;
    localparam logic [47:0] C_ZLZ    = 48'h11_11_11_11_11_00;
    localparam logic [47:0] C_DASH   = 48'h10_10_10_10_10_10;

    function automatic logic [6:0] seg(input logic [7:0] c);
        case (c)
            8'h00: seg = 7'b1000000;
            8'h01: seg = 7'b1111001;
            8'h02: seg = 7'b0100100;
            8'h03: seg = 7'b0110000;
            8'h04: seg = 7'b0011001;
            8'h05: seg = 7'b0010010;
            8'h06: seg = 7'b0000010;
            8'h07: seg = 7'b1111000;
            8'h08: seg = 7'b0000000;
            8'h09: seg = 7'b0010000;
            8'h0A: seg = 7'b0001000;
            8'h0B: seg = 7'b0000011;
            8'h0C: seg = 7'b1000110;
            8'h0D: seg = 7'b0100001;
            8'h0E: seg = 7'b0000110;
            8'h0F: seg = 7'b0001110;
            8'h10: seg = 7'b0111111;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] expect_hex(input logic [47:0] codes, input logic [5:0] blank);
        logic [41:0] r;
        for (int k = 0; k < 6; k++)
            r[7*k +: 7] = blank[k] ? 7'b1111111 : seg(codes[8*k +: 8]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load(input logic [23:0] v, input logic d);
        @(negedge clk);
        in_valid = 1'b1;
        in_value = v;
        in_dec   = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges with in_ready low after an accept, bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
        end
    endtask

    initial begin
        int  cnt;
        logic ok;

        vecs[0]  = '{24'h00A5F3, 1'b0, 1'b1, 48'h11_11_0A_05_0F_03, 1'b0};
        vecs[1]  = '{24'h00A5F3, 1'b0, 1'b0, 48'h00_00_0A_05_0F_03, 1'b0};
        vecs[2]  = '{24'h01E240, 1'b1, 1'b0, C_123456,              1'b0};
        vecs[3]  = '{24'h000000, 1'b1, 1'b1, C_ZLZ,                 1'b0};
        vecs[4]  = '{24'h0F4240, 1'b1, 1'b0, C_DASH,                1'b1};
        vecs[5]  = '{24'h0F4240, 1'b1, 1'b1, C_DASH,                1'b1};
        vecs[6]  = '{24'h123456, 1'b0, 1'b1, C_123456,              1'b0};
        vecs[7]  = '{24'hFFFFFF, 1'b1, 1'b0, C_DASH,                1'b1};
        vecs[8]  = '{24'h0F423F, 1'b1, 1'b0, 48'h09_09_09_09_09_09, 1'b0};
        vecs[9]  = '{24'h000064, 1'b1, 1'b1, 48'h11_11_11_01_00_00, 1'b0};
        vecs[10] = '{24'h0F0000, 1'b0, 1'b1, 48'h11_0F_00_00_00_00, 1'b0};
        vecs[11] = '{24'h000000, 1'b0, 1'b1, C_ZLZ,                 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        in_dec   = 1'b0;
        blank_lz = 1'b0;
        blink_en = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_ready", 64'(in_ready), 64'd1);
        check("reset_hex", 64'(HEX), 64'(expect_hex(C_ZERO, 6'b0)));
        check("reset_ovf", 64'(overflow), 64'd0);
        blank_lz = 1'b1;
        #1;
        check("reset_hex_lz", 64'(HEX), 64'(expect_hex(C_ZLZ, 6'b0)));

        for (int i = 0; i < 12; i++) begin
            blank_lz = vecs[i].lz;
            load(vecs[i].value, vecs[i].dec);
            if (vecs[i].dec) begin
                wait_ready(cnt);
                check($sformatf("v%0d_latency", i), 64'(cnt), 64'd25);
            end else begin
                @(negedge clk);
                check($sformatf("v%0d_ready", i), 64'(in_ready), 64'd1);
            end
            check($sformatf("v%0d_hex", i), 64'(HEX), 64'(expect_hex(vecs[i].codes, 6'b0)));
            check($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
        end

        // Blink on digit 0 only.
        blank_lz = 1'b0;
        load(24'h123456, 1'b0);
        blink_en = 6'b000001;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", c), 64'(HEX),
                  64'(expect_hex(C_123456, ((n_edges / 4) % 2 == 1) ? 6'b000001 : 6'b0)));
        end
        blink_en = '0;

        // Reset in the middle of a conversion discards it.
        load(24'h01E240, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_ready", 64'(in_ready), 64'd1);
        check("midreset_hex", 64'(HEX), 64'(expect_hex(C_ZERO, 6'b0)));
        check("midreset_ovf", 64'(overflow), 64'd0);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (HEX !== expect_hex(C_ZERO, 6'b0) || in_ready !== 1'b1) ok = 1'b0;
        end
        check("midreset_no_stale", 64'(ok), 64'd1);

        // in_valid pulses during conversion are ignored.
        load(24'h01E240, 1'b1);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            in_valid = (cnt == 3 || cnt == 10 || cnt == 20);
            in_value = 24'h999999;
            in_dec   = 1'b0;
        end
        in_valid = 1'b0;
        check("pulse_latency", 64'(cnt), 64'd25);
        check("pulse_hex", 64'(HEX), 64'(expect_hex(C_123456, 6'b0)));
        @(negedge clk);
        check("pulse_hex_hold", 64'(HEX), 64'(expect_hex(C_123456, 6'b0)));
        check("pulse_ovf", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
